// File: rtl/alu_cmd_sequencer_if.sv
// Host-side command/response handshake bundle for alu_cmd_sequencer.
// Master is the host; slave is the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_a,
    output cmd_b,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_a,
    input  cmd_b,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequencer in front of the combinational ALU: logic ops in one
// drive cycle, MUL as WIDTH shift-and-add steps on the ALU adder.
module alu_cmd_sequencer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] SEL_ADD = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    MUL_STEP,
    RESP
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand_nxt;

  // The ALU adder output is only taken when the current multiplier bit is set.
  always_comb begin
    acc_nxt   = mplier[0] ? alu_out : acc;
    mcand_nxt = mcand << 1;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            unique case (1'b1)
              !bus.cmd_op[2]: begin
                state   <= DRIVE;
                alu_a   <= bus.cmd_a;
                alu_b   <= bus.cmd_b;
                alu_sel <= bus.cmd_op[1:0];
              end
              bus.cmd_op == 3'b100: begin
                state   <= MUL_STEP;
                acc     <= '0;
                mcand   <= bus.cmd_a;
                mplier  <= bus.cmd_b;
                cnt     <= '0;
                alu_a   <= '0;
                alu_b   <= bus.cmd_a;
                alu_sel <= SEL_ADD;
              end
              default: begin
                state       <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end

        DRIVE: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= alu_out;
          rsp_err_q   <= 1'b0;
          alu_a       <= '0;
          alu_b       <= '0;
          alu_sel     <= 2'b00;
        end

        MUL_STEP: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= acc_nxt;
            rsp_err_q   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= 2'b00;
          end else begin
            alu_a <= acc_nxt;
            alu_b <= mcand_nxt;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
